// File: rtl/mem_pkg.sv
// Shared types and constants for the mem_sync block.
package mem_pkg;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam int unsigned RD_LAT_MIN = 1;
    localparam int unsigned RD_LAT_MAX = 2;

    // Out-of-range latencies fold onto the nearest legal value.
    function automatic int unsigned rd_lat_clamp(input int unsigned lat);
        if (lat <= RD_LAT_MIN) return RD_LAT_MIN;
        if (lat >= RD_LAT_MAX) return RD_LAT_MAX;
        return lat;
    endfunction

    function automatic int unsigned depth_of(input int unsigned aw);
        return 32'd1 << aw;
    endfunction

endpackage

// File: rtl/mem_array.sv
// Word storage: one write port, one synchronous read port whose output
// register is zero on cycles without a read.
module mem_array
    import mem_pkg::*;
#(
    parameter int unsigned DWIDTH = 8,
    parameter int unsigned AWIDTH = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [AWIDTH-1:0] waddr,
    input  logic [DWIDTH-1:0] wdata,
    input  logic              re,
    input  logic [AWIDTH-1:0] raddr,
    output logic [DWIDTH-1:0] rdata
);

    localparam int unsigned DEPTH = depth_of(AWIDTH);

    logic [DWIDTH-1:0] mem [DEPTH];

    // Contents are never reset; the init sequence clears them.
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    always_ff @(posedge clk) begin
        if (rst)     rdata <= '0;
        else if (re) rdata <= mem[raddr];
        else         rdata <= '0;
    end

endmodule

// File: rtl/mem_sync.sv
// Synchronous RAM with self-initialisation sequence and pipelined reads.
module mem_sync
    import mem_pkg::*;
#(
    parameter int unsigned       DWIDTH   = 8,
    parameter int unsigned       AWIDTH   = 5,
    parameter int unsigned       RD_LAT   = 1,
    parameter logic [DWIDTH-1:0] INIT_VAL = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [AWIDTH-1:0] req_addr,
    input  logic [DWIDTH-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DWIDTH-1:0] rsp_rdata,
    output logic              busy
);

    localparam int unsigned LAT = rd_lat_clamp(RD_LAT);

    state_t            state;
    state_t            state_next;
    logic              busy_d;
    logic              ready_d;
    logic [AWIDTH-1:0] init_cnt;
    logic              init_last;
    logic              accept;
    logic              rd_acc;
    logic              wr_acc;
    logic              mem_we;
    logic [AWIDTH-1:0] mem_waddr;
    logic [DWIDTH-1:0] mem_wdata;
    logic              v1;
    logic [DWIDTH-1:0] rd1;

    assign init_last = (init_cnt == '1);
    assign accept    = req_valid & req_ready & ~rst;
    assign rd_acc    = accept & ~req_we;
    assign wr_acc    = accept & req_we;

    always_ff @(posedge clk) begin
        if (rst) state <= INIT;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            INIT:    if (init_last) state_next = RUN;
            RUN:     state_next = RUN;
            default: state_next = INIT;
        endcase
    end

    always_comb begin
        busy_d  = 1'b0;
        ready_d = 1'b0;
        if (state_next == INIT) busy_d  = 1'b1;
        else                    ready_d = 1'b1;
    end

    // Status outputs are registered from the next state so they line up with it.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy      <= 1'b1;
            req_ready <= 1'b0;
        end else begin
            busy      <= busy_d;
            req_ready <= ready_d;
        end
    end

    // Counter saturates on the last address rather than wrapping.
    always_ff @(posedge clk) begin
        if (rst)                          init_cnt <= '0;
        else if (state == INIT && !init_last) init_cnt <= init_cnt + AWIDTH'(1);
    end

    always_comb begin
        mem_we    = wr_acc;
        mem_waddr = req_addr;
        mem_wdata = req_wdata;
        if (state == INIT) begin
            mem_we    = 1'b1;
            mem_waddr = init_cnt;
            mem_wdata = INIT_VAL;
        end
    end

    mem_array #(
        .DWIDTH (DWIDTH),
        .AWIDTH (AWIDTH)
    ) u_array (
        .clk   (clk),
        .rst   (rst),
        .we    (mem_we),
        .waddr (mem_waddr),
        .wdata (mem_wdata),
        .re    (rd_acc),
        .raddr (req_addr),
        .rdata (rd1)
    );

    always_ff @(posedge clk) begin
        if (rst) v1 <= 1'b0;
        else     v1 <= rd_acc;
    end

    if (LAT == 1) begin : g_lat1
        assign rsp_valid = v1;
        assign rsp_rdata = rd1;
    end else begin : g_lat2
        logic              v2;
        logic [DWIDTH-1:0] d2;

        always_ff @(posedge clk) begin
            if (rst) begin
                v2 <= 1'b0;
                d2 <= '0;
            end else begin
                v2 <= v1;
                d2 <= v1 ? rd1 : '0;
            end
        end

        assign rsp_valid = v2;
        assign rsp_rdata = d2;
    end

endmodule

// File: doc/mem_sync.md
MEM_SYNC -- requirements
Module: mem_sync

Interface
REQ-001 Parameter DWIDTH, default 8, data word width in bits; legal range 1..64.
REQ-002 Parameter AWIDTH, default 5, address width; depth = 2**AWIDTH words.
REQ-003 Parameter RD_LAT, default 1, read latency in cycles; legal values 1 or 2.
REQ-004 Parameter INIT_VAL, default 0, DWIDTH-bit value written to every word by the init sequence.
REQ-005 clk  input  1  single clock; all state updates on its rising edge.
REQ-006 rst  input  1  reset; synchronous, active-high.
REQ-007 req_valid  input  1  request present this cycle.
REQ-008 req_ready  output  1  block can accept a request this cycle.
REQ-009 req_we  input  1  1 = write, 0 = read.
REQ-010 req_addr  input  AWIDTH  word address.
REQ-011 req_wdata  input  DWIDTH  write data.
REQ-012 rsp_valid  output  1  read data valid; one-cycle pulse per accepted read.
REQ-013 rsp_rdata  output  DWIDTH  read data; all-zero whenever rsp_valid=0.
REQ-014 busy  output  1  init sequence in progress.

Function
REQ-015 FSM states: INIT and RUN; reset enters INIT.
REQ-016 INIT: a counter walks addresses 0..2**AWIDTH-1, one per cycle, writing INIT_VAL; after the last address is written, the next state is RUN. Total INIT duration = 2**AWIDTH cycles.
REQ-017 busy=1 and req_ready=0 throughout INIT; busy=0 and req_ready=1 throughout RUN.
REQ-018 A request is accepted on a cycle where req_valid=1 and req_ready=1; requests presented with req_ready=0 are ignored, not queued.
REQ-019 Accepted write: mem[req_addr] <= req_wdata at the accepting edge; no response is generated.
REQ-020 Accepted read at edge N: rsp_valid=1 with rsp_rdata=mem[req_addr] in the cycle following edge N+RD_LAT-1 (RD_LAT=1: the cycle immediately after acceptance).
REQ-021 Reads are fully pipelined: back-to-back reads are accepted every cycle, and responses are returned in request order with no gaps.
REQ-022 Read-after-write: a read accepted in the cycle after a write to the same address returns the new data.
REQ-023 A single request is either a read or a write; there are no simultaneous read and write.
REQ-024 Response has no backpressure; the consumer must accept every rsp_valid pulse.
REQ-025 Address wrap: addresses are modulo 2**AWIDTH; the init counter saturates at its final value and does not wrap.

Reset
REQ-026 On rst=1 at a clock edge: state <= INIT, init counter <= 0, rsp_valid <= 0, rsp_rdata <= 0, all read-pipeline valid bits <= 0.
REQ-027 Reset mid-INIT restarts the init sequence from address 0.
REQ-028 Reset with reads in flight discards those reads; no rsp_valid pulse appears for them after reset.
REQ-029 Memory array contents are not reset directly; they are cleared only by the INIT sequence.

Structure
REQ-030 Shared package mem_pkg holds the FSM state enum (INIT, RUN) and the legal-RD_LAT constants.
REQ-031 Storage is a sub-module mem_array: single write port, single synchronous read port, parameterised by DWIDTH and AWIDTH.
REQ-032 mem_sync contains the FSM, the init counter, the request-accept logic and the RD_LAT-deep valid/data pipeline.

Verification
REQ-033 Reset, then idle: busy=1 for exactly 32 cycles (AWIDTH=5), then req_ready=1; reading all 32 addresses returns INIT_VAL.
REQ-034 Write data=addr to addresses 0..31, then read 0..31 back-to-back: 32 consecutive rsp_valid pulses, each with rsp_rdata equal to its address.
REQ-035 RD_LAT=2: read of addr 5 accepted at cycle N -> rsp_valid=1 only in cycle N+2, data=8'h05.
REQ-036 Write 8'hA5 to addr 3, then read addr 3 in the next cycle -> response data 8'hA5.
REQ-037 Issue 3 reads, then assert rst on the next edge -> no rsp_valid afterwards; INIT restarts and busy=1 for 32 cycles.
REQ-038 req_valid=1 during INIT with a write of 8'hFF to addr 0 -> ignored; after INIT, reading addr 0 returns INIT_VAL.
